// File: rtl/ddr_pkg.sv
// Shared encodings for the DDR5 request-level command scheduler:
// FSM state codes, command codes and request-address field positions.
package ddr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRE      = 4'd1,
    ST_WAIT_RP  = 4'd2,
    ST_ACT      = 4'd3,
    ST_WAIT_ACT = 4'd4,
    ST_RDWR     = 4'd5,
    ST_PREA     = 4'd6,
    ST_REF      = 4'd7,
    ST_WAIT_RFC = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;

  localparam int BA_BIT    = 20;
  localparam int ROW_MSB   = 15;
  localparam int ROW_LSB   = 8;
  localparam int COL_MSB   = 7;
  localparam int COL_LSB   = 0;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 10;
  localparam int NUM_BANKS = 2;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/ddr_cmd_sched_tim_cnt.sv
// Loadable down-counter that parks at zero; zero_o flags the terminal count.
// Reset preloads the counter with the current load value.
module tim_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= load_val_i;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_cmd_sched.sv
// Request-level DDR5 command scheduler: open-row tracking per bank, ACT/RD/WR/PRE
// sequencing with t_act/t_rp/t_rfc spacing, and periodic PREA+REF refresh.
module ddr_cmd_sched #(
  parameter int t_act  = 3,
  parameter int t_rp   = 2,
  parameter int t_rfc  = 8,
  parameter int t_refi = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  output logic [2:0]  cmd,
  output logic        cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic [3:0]  current_state,
  output logic        busy
);
  import ddr_pkg::*;

  // Wait counters run t-1 cycles: loaded with t-2 in the issuing state, exit on zero.
  localparam logic [CNT_W-1:0] ACT_LD  = CNT_W'(t_act - 2);
  localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(t_rp - 2);
  localparam logic [CNT_W-1:0] RFC_LD  = CNT_W'(t_rfc - 2);
  localparam logic [CNT_W-1:0] REFI_LD = CNT_W'(t_refi - 1);

  state_e               state_q, state_d;
  logic                 ref_pend_q, ref_pend_d;
  logic                 rp_to_ref_q, rp_to_ref_d;
  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ROW_W-1:0]     orow_q [NUM_BANKS];

  logic                 lat_ba_q;
  logic [ROW_W-1:0]     lat_row_q;
  logic [COL_W-1:0]     lat_col_q;
  logic                 lat_we_q;

  logic                 in_ba;
  logic [ROW_W-1:0]     in_row;
  logic [COL_W-1:0]     in_col;
  logic                 acc;
  logic                 wt_load;
  logic [CNT_W-1:0]     wt_val;
  logic                 wt_zero;
  logic                 ref_zero;
  cmd_e                 cmd_c;
  logic                 unused_addr;

  assign in_ba  = req_addr[BA_BIT];
  assign in_row = {8'd0, req_addr[ROW_MSB:ROW_LSB]};
  assign in_col = {2'd0, req_addr[COL_MSB:COL_LSB]};
  assign unused_addr = ^{req_addr[31:BA_BIT+1], req_addr[BA_BIT-1:ROW_MSB+1]};

  assign req_ready     = (state_q == ST_IDLE) && !ref_pend_q;
  assign busy          = (state_q != ST_IDLE) || ref_pend_q;
  assign acc           = req_valid && req_ready;
  assign current_state = state_q;

  tim_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (wt_load),
    .load_val_i(wt_val),
    .zero_o    (wt_zero)
  );

  // Free-running refresh interval: reloads itself on the cycle it reads zero.
  tim_cnt #(.W(CNT_W)) u_refi_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ref_zero),
    .load_val_i(REFI_LD),
    .zero_o    (ref_zero)
  );

  always_comb begin
    state_d     = state_q;
    ref_pend_d  = ref_pend_q;
    rp_to_ref_d = rp_to_ref_q;
    open_d      = open_q;
    wt_load     = 1'b0;
    wt_val      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (ref_pend_q) begin
          state_d = (|open_q) ? ST_PREA : ST_REF;
        end else if (req_valid) begin
          if (!open_q[in_ba])                 state_d = ST_ACT;
          else if (orow_q[in_ba] == in_row)   state_d = ST_RDWR;
          else                                state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        open_d[lat_ba_q] = 1'b0;
        rp_to_ref_d      = 1'b0;
        wt_load          = 1'b1;
        wt_val           = RP_LD;
        state_d          = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (wt_zero) state_d = rp_to_ref_q ? ST_REF : ST_ACT;
      end
      ST_ACT: begin
        open_d[lat_ba_q] = 1'b1;
        wt_load          = 1'b1;
        wt_val           = ACT_LD;
        state_d          = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (wt_zero) state_d = ST_RDWR;
      end
      ST_RDWR: state_d = ST_IDLE;
      ST_PREA: begin
        open_d      = '0;
        rp_to_ref_d = 1'b1;
        wt_load     = 1'b1;
        wt_val      = RP_LD;
        state_d     = ST_WAIT_RP;
      end
      ST_REF: begin
        ref_pend_d = 1'b0;
        wt_load    = 1'b1;
        wt_val     = RFC_LD;
        state_d    = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: begin
        if (wt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ref_zero) ref_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_pend_q  <= 1'b0;
      rp_to_ref_q <= 1'b0;
      open_q      <= '0;
    end else begin
      state_q     <= state_d;
      ref_pend_q  <= ref_pend_d;
      rp_to_ref_q <= rp_to_ref_d;
      open_q      <= open_d;
    end
  end

  // Request latch and open-row values are qualified by state/open flags, so no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      lat_ba_q  <= in_ba;
      lat_row_q <= in_row;
      lat_col_q <= in_col;
      lat_we_q  <= req_we;
    end
    if (state_q == ST_ACT) begin
      orow_q[lat_ba_q] <= lat_row_q;
    end
  end

  always_comb begin
    cmd_c   = CMD_NOP;
    cmd_ba  = 1'b0;
    cmd_row = '0;
    cmd_col = '0;
    unique case (state_q)
      ST_PRE: begin
        cmd_c  = CMD_PRE;
        cmd_ba = lat_ba_q;
      end
      ST_ACT: begin
        cmd_c   = CMD_ACT;
        cmd_ba  = lat_ba_q;
        cmd_row = lat_row_q;
      end
      ST_RDWR: begin
        cmd_c   = lat_we_q ? CMD_WR : CMD_RD;
        cmd_ba  = lat_ba_q;
        cmd_col = lat_col_q;
      end
      ST_PREA: cmd_c = CMD_PREA;
      ST_REF:  cmd_c = CMD_REF;
      default: cmd_c = CMD_NOP;
    endcase
  end

  assign cmd = cmd_c;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Scoreboard bench for ddr_cmd_sched: each request pushes its expected command
// sequence (with issue cycles) into a queue that the command monitor drains.
module tb_ddr_cmd_sched;
  import ddr_pkg::*;

  localparam int T_ACT  = 3;
  localparam int T_RP   = 2;
  localparam int T_RFC  = 8;
  localparam int T_REFI = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  cmd;
  logic        cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [3:0]  current_state;
  logic        busy;

  ddr_cmd_sched #(
    .t_act (T_ACT),
    .t_rp  (T_RP),
    .t_rfc (T_RFC),
    .t_refi(T_REFI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .cmd          (cmd),
    .cmd_ba       (cmd_ba),
    .cmd_row      (cmd_row),
    .cmd_col      (cmd_col),
    .current_state(current_state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic        ba;
    logic [15:0] row;
    logic [9:0]  col;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic        mopen [2];
  logic [15:0] mrow  [2];
  int          free_cyc;
  int          next_ref;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [2:0] k, input logic b,
                               input logic [15:0] r, input logic [9:0] col);
    exp_t e;
    e.cyc = c; e.cmd = k; e.ba = b; e.row = r; e.col = col;
    expq.push_back(e);
  endfunction

  // Refresh becomes pending at next_ref and is serviced at the first idle cycle.
  function automatic void service_refresh();
    int q;
    q = (next_ref > free_cyc) ? next_ref : free_cyc;
    if (mopen[0] || mopen[1]) begin
      push(q + 1, CMD_PREA, 1'b0, 16'd0, 10'd0);
      push(q + 1 + T_RP, CMD_REF, 1'b0, 16'd0, 10'd0);
      free_cyc = q + 1 + T_RP + T_RFC;
    end else begin
      push(q + 1, CMD_REF, 1'b0, 16'd0, 10'd0);
      free_cyc = q + 1 + T_RFC;
    end
    mopen[0] = 1'b0;
    mopen[1] = 1'b0;
    next_ref += T_REFI;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(negedge clk);
      if (next_ref <= cyc) service_refresh();
    end
  endtask

  task automatic send(input logic [31:0] a, input logic we);
    int          c, n, guard;
    logic        b;
    logic [15:0] r;
    logic [9:0]  col;
    logic [2:0]  rw;
    @(negedge clk);
    c = cyc;
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    n = (c > free_cyc) ? c : free_cyc;
    while (next_ref <= n) begin
      service_refresh();
      n = (c > free_cyc) ? c : free_cyc;
    end
    b   = a[20];
    r   = {8'd0, a[15:8]};
    col = {2'd0, a[7:0]};
    rw  = we ? CMD_WR : CMD_RD;
    if (mopen[b] && mrow[b] == r) begin
      push(n + 1, rw, b, 16'd0, col);
      free_cyc = n + 2;
    end else if (!mopen[b]) begin
      push(n + 1, CMD_ACT, b, r, 10'd0);
      push(n + 1 + T_ACT, rw, b, 16'd0, col);
      free_cyc = n + 2 + T_ACT;
    end else begin
      push(n + 1, CMD_PRE, b, 16'd0, 10'd0);
      push(n + 1 + T_RP, CMD_ACT, b, r, 10'd0);
      push(n + 1 + T_RP + T_ACT, rw, b, 16'd0, col);
      free_cyc = n + 2 + T_RP + T_ACT;
    end
    mopen[b] = 1'b1;
    mrow[b]  = r;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      check_eq("ready_low_while_busy", req_ready, 1'b0);
      check_eq("busy_high", busy, 1'b1);
      @(negedge clk);
      guard++;
    end
    check_eq("accept_cycle", cyc, n);
    check_eq("ready_at_accept", req_ready, 1'b1);
    check_eq("busy_low_at_accept", busy, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        check_eq("cmd_missing_by_cycle", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
      if (cmd != CMD_NOP) begin
        if (expq.size() == 0) begin
          check_eq("unexpected_cmd", cmd, CMD_NOP);
        end else begin
          mon_e = expq.pop_front();
          check_eq("cmd_code", cmd, mon_e.cmd);
          check_eq("cmd_ba", cmd_ba, mon_e.ba);
          check_eq("cmd_row", cmd_row, mon_e.row);
          check_eq("cmd_col", cmd_col, mon_e.col);
          check_eq("cmd_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check_eq("nop_fields_zero", {5'd0, cmd_ba, cmd_row, cmd_col}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    mopen[0] = 1'b0; mopen[1] = 1'b0;
    mrow[0]  = '0;   mrow[1]  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    free_cyc = cyc;
    next_ref = cyc + T_REFI;
    check_eq("rst_state", current_state, ST_IDLE);
    check_eq("rst_cmd", cmd, CMD_NOP);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);

    // First refresh with every bank closed: REF without PREA.
    wait_until(next_ref + 12);

    // Closed bank, row hit, row miss, other bank, hit after other bank.
    send(32'h0010_1234, 1'b0);
    send(32'h0010_1256, 1'b1);
    send(32'h0010_3400, 1'b0);
    send(32'h0000_1200, 1'b0);
    send(32'h0010_3401, 1'b0);

    // Request held as the refresh goes pending with both banks open.
    wait_until(next_ref - 1);
    send(32'h0010_1234, 1'b0);

    // Request accepted in the very cycle the refresh counter reads zero.
    wait_until(next_ref - 2);
    send(32'h0010_1234, 1'b1);
    wait_until(cyc + 20);

    // Reset during WAIT_ACT, then the same row must be activated again.
    send(32'h0010_5678, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_eq("state_wait_act", current_state, ST_WAIT_ACT);
    expq.delete();
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_state", current_state, ST_IDLE);
    check_eq("midrst_cmd", cmd, CMD_NOP);
    rst = 1'b0;
    mopen[0] = 1'b0; mopen[1] = 1'b0;
    free_cyc = cyc;
    next_ref = cyc + T_REFI;
    send(32'h0010_5678, 1'b1);
    k = cyc + 15;
    wait_until(k);
    check_eq("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Request-level command scheduler for the DDR5 controller. It accepts one read/write request at a time and decodes the bank, row and column from the request address. It tracks the open row of each bank and issues the ACT / RD / WR / PRE / PREA / REF command sequence with the t_act, t_rp and t_rfc spacing. It also generates periodic refresh and exports its state on `current_state` for the address LUT and datapath downstream.

## Interface
- `t_act`, default 3: cycles from ACT issue to RD/WR issue; must be ≥ 2.
- `t_rp`, default 2: cycles from PRE/PREA issue to the next ACT/REF issue; must be ≥ 2.
- `t_rfc`, default 8: cycles from REF issue to return to IDLE; must be ≥ 2.
- `t_refi`, default 64: refresh interval in cycles.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in 32: bank = [20], row = {8'd0,[15:8]}, col = {2'd0,[7:0]}.
- `req_we` in 1: 1 = write, 0 = read.
- `cmd` out 3: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6.
- `cmd_ba` out 1: bank of the command.
- `cmd_row` out 16: row (ACT only).
- `cmd_col` out 10: column (RD/WR only).
- `current_state` out 4: FSM state code.
- `busy` out 1: state ≠ IDLE or `ref_pending`.

## Operation
- FSM states: IDLE=0, PRE=1, WAIT_RP=2, ACT=3, WAIT_ACT=4, RDWR=5, PREA=6, REF=7, WAIT_RFC=8.
- `req_ready` = (state==IDLE) && !ref_pending. It depends only on registers.
- On accept, latch addr/we and branch on the open-row table (per bank: open flag + 16-bit row):
  - bank open, same row → RDWR;
  - bank closed → ACT;
  - bank open, different row → PRE.
- PRE: cmd=PRE, ba=latched bank; clear that bank's open flag → WAIT_RP.
- WAIT_RP: hold for t_rp−1 cycles.
  - Exit to ACT if entered from PRE.
  - Exit to REF if entered from PREA.
- ACT: cmd=ACT, ba/row from the latched request; set the open flag and row → WAIT_ACT.
- WAIT_ACT: hold for t_act−1 cycles → RDWR.
- RDWR: cmd=WR if we, else RD; ba/col from the latch → IDLE.
- Refresh timer:
  - Free-running down-counter, reloaded with t_refi−1 on reaching 0.
  - Reaching 0 sets `ref_pending`. A second expiry while it is already set has no additional effect.
- IDLE with `ref_pending`:
  - any bank open → PREA (cmd=PREA, clears all open flags) → WAIT_RP → REF;
  - else → REF.
- REF: cmd=REF, clear `ref_pending` → WAIT_RFC.
- WAIT_RFC: hold for t_rfc−1 cycles → IDLE.
- A pending refresh never preempts a sequence already in progress. It is serviced at the next IDLE, ahead of any request.
- Unused cmd fields are 0. Every field is 0 while cmd=NOP.

## Timing
- Reset: state=IDLE, all cmd outputs 0, open flags 0, `ref_pending`=0, refresh counter=t_refi−1.
  - The cycle after `rst` falls: `req_ready`=1, `busy`=0.
- `rst` mid-sequence: the next state is IDLE with all state above cleared. No PRE is issued.
- Command outputs are Moore: decoded from the state and the latched request. There is no combinational path from `req_*` to `cmd*`.
- Latency, with the request accepted in cycle n:
  - hit: RD/WR at n+1;
  - closed bank: ACT at n+1, RD/WR at n+1+t_act;
  - miss: PRE at n+1, ACT at n+1+t_rp, RD/WR at n+1+t_rp+t_act.
- `req_ready` rises in the cycle after RDWR.
- The counter reaches 0 in a cycle where a request is accepted: the request is served first, then the refresh.
- Refresh with open banks: PREA at m, REF at m+t_rp, IDLE at m+t_rp+t_rfc.

## Structure
- Package `ddr_pkg`:
  - state codes;
  - cmd codes;
  - address field positions (BA_BIT=20, ROW_MSB/LSB=15/8, COL_MSB/LSB=7:0).
- Sub-module `tim_cnt`: loadable down-counter with load value, load strobe and `zero` flag.
  - One instance serves the WAIT_* states.
  - One instance serves the refresh interval.

## Test plan
All cases use t_act=3, t_rp=2, t_rfc=8, t_refi=64.
1. Closed bank: after reset, request read 0x0010_1234 accepted at cycle 0 → ACT ba=1 row=0x0012 at cycle 1, RD ba=1 col=0x034 at cycle 4, `req_ready`=1 at cycle 5.
2. Row hit: then write 0x0010_1256 → WR ba=1 col=0x056 in the cycle after accept, with no ACT.
3. Row miss: read 0x0010_3400 → PRE ba=1 at +1, ACT row=0x0034 at +3, RD col=0 at +6.
4. Other bank: read 0x0000_1200 → ACT ba=0. A following read to 0x0010_3401 is a hit (RD at +1).
5. Refresh: let the counter expire with both banks open and `req_valid` held → `req_ready`=0, PREA, REF 2 cycles later, IDLE 8 cycles after REF. The held request is then served as closed-bank (ACT first).
6. Reset mid-operation: `rst` during WAIT_ACT → next cycle state=0, cmd=NOP. A re-issued request to the same row produces an ACT.
